// File: rtl/vga_bounce_sdl.sv
// Bouncing-square test pattern with its own display timing generator; all outputs registered.
// Optional border overlay: define VGA_BOUNCE_BORDER_EN.

module display_timings #(
  parameter int CORDW    = 10,
  parameter int G_H_RES  = 640,
  parameter int G_V_RES  = 480,
  parameter int G_H_FP   = 16,
  parameter int G_H_SYNC = 96,
  parameter int G_H_BP   = 48,
  parameter int G_V_FP   = 10,
  parameter int G_V_SYNC = 2,
  parameter int G_V_BP   = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [CORDW-1:0] o_sx,
  output logic [CORDW-1:0] o_sy,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de
);
  localparam int H_TOT = G_H_RES + G_H_FP + G_H_SYNC + G_H_BP;
  localparam int V_TOT = G_V_RES + G_V_FP + G_V_SYNC + G_V_BP;
  localparam int H_SS  = G_H_RES + G_H_FP;
  localparam int V_SS  = G_V_RES + G_V_FP;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sx <= '0;
      o_sy <= '0;
    end else if (o_sx == CORDW'(H_TOT - 1)) begin
      o_sx <= '0;
      o_sy <= (o_sy == CORDW'(V_TOT - 1)) ? '0 : o_sy + 1'b1;
    end else begin
      o_sx <= o_sx + 1'b1;
    end
  end

  // negative-polarity syncs
  assign o_hsync = ~((o_sx >= CORDW'(H_SS)) && (o_sx < CORDW'(H_SS + G_H_SYNC)));
  assign o_vsync = ~((o_sy >= CORDW'(V_SS)) && (o_sy < CORDW'(V_SS + G_V_SYNC)));
  assign o_de    = (o_sx < CORDW'(G_H_RES)) && (o_sy < CORDW'(G_V_RES));
endmodule

module vga_bounce_sdl #(
  parameter int          CORDW     = 10,
  parameter int          G_H_RES   = 640,
  parameter int          G_V_RES   = 480,
  parameter int          G_H_FP    = 16,
  parameter int          G_H_SYNC  = 96,
  parameter int          G_H_BP    = 48,
  parameter int          G_V_FP    = 10,
  parameter int          G_V_SYNC  = 2,
  parameter int          G_V_BP    = 33,
  parameter int          COLR_W    = 8,
  parameter int          SQ_SIZE   = 64,
  parameter int          SPEED     = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [11:0] FG_RGB    = 12'hFFF,
  parameter logic [11:0] BG_RGB    = 12'h137
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pause,
  output logic [CORDW-1:0]  sdl_sx,
  output logic [CORDW-1:0]  sdl_sy,
  output logic              sdl_de,
  output logic [COLR_W-1:0] sdl_r,
  output logic [COLR_W-1:0] sdl_g,
  output logic [COLR_W-1:0] sdl_b,
  output logic              o_h_sync,
  output logic              o_v_sync,
  output logic              o_frame
);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int REP   = (COLR_W + 3) / 4;
  localparam logic [CORDW:0]   C_SPEED    = (CORDW+1)'(SPEED);
  localparam logic [CORDW:0]   C_SQ       = (CORDW+1)'(SQ_SIZE);
  localparam logic [CORDW:0]   C_X_MAX    = (CORDW+1)'(G_H_RES - SQ_SIZE);
  localparam logic [CORDW:0]   C_Y_MAX    = (CORDW+1)'(G_V_RES - SQ_SIZE);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [CORDW-1:0] w_sx, w_sy;
  logic             w_hs, w_vs, w_de, w_frame, w_in_sq, w_fg;
  logic [CORDW-1:0] r_qx, r_qy, w_qx_n, w_qy_n;
  logic             r_dx, r_dy, w_dx_n, w_dy_n;
  logic [CORDW:0]   w_x_up, w_y_up;
  logic [DIV_W-1:0] r_div;
  logic [11:0]      w_rgb;

  display_timings #(
    .CORDW(CORDW), .G_H_RES(G_H_RES), .G_V_RES(G_V_RES),
    .G_H_FP(G_H_FP), .G_H_SYNC(G_H_SYNC), .G_H_BP(G_H_BP),
    .G_V_FP(G_V_FP), .G_V_SYNC(G_V_SYNC), .G_V_BP(G_V_BP)
  ) u_timings (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_sx(w_sx), .o_sy(w_sy),
    .o_hsync(w_hs), .o_vsync(w_vs), .o_de(w_de)
  );

  assign w_frame = (w_sx == '0) && (w_sy == CORDW'(G_V_RES));

  // one bounce step on both axes, evaluated at CORDW+1 bits
  always_comb begin
    w_qx_n = r_qx;
    w_dx_n = r_dx;
    w_qy_n = r_qy;
    w_dy_n = r_dy;
    w_x_up = {1'b0, r_qx} + C_SPEED;
    w_y_up = {1'b0, r_qy} + C_SPEED;
    if (r_dx) begin
      if (w_x_up >= C_X_MAX) begin
        w_qx_n = C_X_MAX[CORDW-1:0];
        w_dx_n = 1'b0;
      end else begin
        w_qx_n = w_x_up[CORDW-1:0];
      end
    end else if ({1'b0, r_qx} <= C_SPEED) begin
      w_qx_n = '0;
      w_dx_n = 1'b1;
    end else begin
      w_qx_n = r_qx - C_SPEED[CORDW-1:0];
    end
    if (r_dy) begin
      if (w_y_up >= C_Y_MAX) begin
        w_qy_n = C_Y_MAX[CORDW-1:0];
        w_dy_n = 1'b0;
      end else begin
        w_qy_n = w_y_up[CORDW-1:0];
      end
    end else if ({1'b0, r_qy} <= C_SPEED) begin
      w_qy_n = '0;
      w_dy_n = 1'b1;
    end else begin
      w_qy_n = r_qy - C_SPEED[CORDW-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_qx  <= '0;
      r_qy  <= '0;
      r_dx  <= 1'b1;
      r_dy  <= 1'b1;
      r_div <= '0;
    end else if (w_frame && !i_pause) begin
      if (r_div < C_DIV_LAST) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div <= '0;
        r_qx  <= w_qx_n;
        r_qy  <= w_qy_n;
        r_dx  <= w_dx_n;
        r_dy  <= w_dy_n;
      end
    end
  end

  assign w_in_sq = ({1'b0, w_sx} >= {1'b0, r_qx}) && ({1'b0, w_sx} < ({1'b0, r_qx} + C_SQ)) &&
                   ({1'b0, w_sy} >= {1'b0, r_qy}) && ({1'b0, w_sy} < ({1'b0, r_qy} + C_SQ));

`ifdef VGA_BOUNCE_BORDER_EN
  assign w_fg = w_in_sq || (w_sx == '0) || (w_sx == CORDW'(G_H_RES - 1)) ||
                (w_sy == '0) || (w_sy == CORDW'(G_V_RES - 1));
`else
  assign w_fg = w_in_sq;
`endif

  assign w_rgb = w_fg ? FG_RGB : BG_RGB;

  function automatic logic [COLR_W-1:0] f_expand(input logic [3:0] nib);
    logic [4*REP-1:0] rep;
    rep = {REP{nib}};
    return rep[4*REP-1 -: COLR_W];
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sdl_sx   <= '0;
      sdl_sy   <= '0;
      sdl_de   <= 1'b0;
      sdl_r    <= '0;
      sdl_g    <= '0;
      sdl_b    <= '0;
      o_h_sync <= 1'b1;
      o_v_sync <= 1'b1;
      o_frame  <= 1'b0;
    end else begin
      sdl_sx   <= w_sx;
      sdl_sy   <= w_sy;
      sdl_de   <= w_de;
      sdl_r    <= w_de ? f_expand(w_rgb[11:8]) : '0;
      sdl_g    <= w_de ? f_expand(w_rgb[7:4])  : '0;
      sdl_b    <= w_de ? f_expand(w_rgb[3:0])  : '0;
      o_h_sync <= w_hs;
      o_v_sync <= w_vs;
      o_frame  <= w_frame;
    end
  end
endmodule

// File: tb/tb_vga_bounce_sdl.sv
// Bench for vga_bounce_sdl: three small-timing instances checked every cycle against a frame-level model.
module tb_vga_bounce_sdl;
  localparam int HR = 16, VR = 12, HFP = 2, HSY = 2, HBP = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HR + HFP + HSY + HBP;
  localparam int VT = VR + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic longint expand(input int nib, input int w);
    longint v;
    int reps;
    v = 0;
    reps = (w + 3) / 4;
    for (int k = 0; k < reps; k++) v = (v << 4) | longint'(nib);
    return v >> (reps * 4 - w);
  endfunction

  function automatic logic [63:0] rgb_of(input int rgb, input int w);
    return 64'((expand((rgb >> 8) & 15, w) << (2 * w)) | (expand((rgb >> 4) & 15, w) << w) |
               expand(rgb & 15, w));
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CW = (gi == 0) ? 8 : (gi == 1) ? 4 : 12;
    localparam int FD = (gi == 0) ? 1 : 3;
    localparam int SP = (gi == 0) ? 3 : 2;
    localparam int SQ = (gi == 0) ? 4 : 5;
    logic [9:0]    sx, sy;
    logic          de, hs, vs, fr;
    logic [CW-1:0] cr, cg, cb;

    vga_bounce_sdl #(
      .CORDW(10), .G_H_RES(HR), .G_V_RES(VR), .G_H_FP(HFP), .G_H_SYNC(HSY), .G_H_BP(HBP),
      .G_V_FP(VFP), .G_V_SYNC(VSY), .G_V_BP(VBP), .COLR_W(CW), .SQ_SIZE(SQ), .SPEED(SP),
      .FRAME_DIV(FD), .FG_RGB(12'hFFF), .BG_RGB(12'h137)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pause(pause),
      .sdl_sx(sx), .sdl_sy(sy), .sdl_de(de), .sdl_r(cr), .sdl_g(cg), .sdl_b(cb),
      .o_h_sync(hs), .o_v_sync(vs), .o_frame(fr)
    );

    // At each falling edge: check outputs of the edge just passed, then predict the next edge.
    initial begin : model
      int msx, msy, qx, qy, dx, dy, dv;
      int esx, esy, ede, ehs, evs, efr;
      logic [63:0] ergb;
      bit have, fgp;
      have = 0;
      forever begin
        @(negedge clk);
        if (have) begin
          chk($sformatf("u%0d sx", gi), 64'(sx), 64'(esx));
          chk($sformatf("u%0d sy", gi), 64'(sy), 64'(esy));
          chk($sformatf("u%0d de", gi), 64'(de), 64'(ede));
          chk($sformatf("u%0d hsync", gi), 64'(hs), 64'(ehs));
          chk($sformatf("u%0d vsync", gi), 64'(vs), 64'(evs));
          chk($sformatf("u%0d frame", gi), 64'(fr), 64'(efr));
          chk($sformatf("u%0d rgb", gi), 64'({cr, cg, cb}), ergb);
        end
        if (!rst_n) begin
          esx = 0; esy = 0; ede = 0; ehs = 1; evs = 1; efr = 0; ergb = '0;
          msx = 0; msy = 0; qx = 0; qy = 0; dx = 1; dy = 1; dv = 0;
          have = 1;
        end else if (have) begin
          esx = msx;
          esy = msy;
          ede = int'(msx < HR && msy < VR);
          ehs = int'(!(msx >= HR + HFP && msx < HR + HFP + HSY));
          evs = int'(!(msy >= VR + VFP && msy < VR + VFP + VSY));
          efr = int'(msx == 0 && msy == VR);
          fgp = (msx >= qx) && (msx < qx + SQ) && (msy >= qy) && (msy < qy + SQ);
`ifdef VGA_BOUNCE_BORDER_EN
          if (msx == 0 || msx == HR - 1 || msy == 0 || msy == VR - 1) fgp = 1;
`endif
          ergb = (ede != 0) ? rgb_of(fgp ? 12'hFFF : 12'h137, CW) : '0;
          if (efr != 0 && !pause) begin
            if (dv < FD - 1) dv++;
            else begin
              dv = 0;
              if (dx == 1) begin
                if (qx + SP >= HR - SQ) begin qx = HR - SQ; dx = 0; end else qx += SP;
              end else begin
                if (qx <= SP) begin qx = 0; dx = 1; end else qx -= SP;
              end
              if (dy == 1) begin
                if (qy + SP >= VR - SQ) begin qy = VR - SQ; dy = 0; end else qy += SP;
              end else begin
                if (qy <= SP) begin qy = 0; dy = 1; end else qy -= SP;
              end
            end
          end
          msx++;
          if (msx == HT) begin
            msx = 0;
            msy++;
            if (msy == VT) msy = 0;
          end
        end
      end
    end
  end

  task automatic do_reset(output int n);
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    n = 1;
    chk("reset sx", 64'(g_dut[0].sx), 64'd0);
    chk("reset rgb", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'd0);
    chk("reset syncs", 64'({g_dut[0].hs, g_dut[0].vs, g_dut[0].fr}), 64'b110);
    while (!g_dut[0].fr && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic frame_gap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_dut[0].fr && n < 3 * FRAME);
  endtask

  task automatic wait_px(input int x, input int y);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (g_dut[0].sx == 10'(x) && g_dut[0].sy == 10'(y)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_px (%0d,%0d): pixel not reached, required within %0d cycles", x, y, 2 * FRAME);
    end
  endtask

  initial begin
    int n;
    do_reset(n);
    chk("first frame latency", 64'(n), 64'd266);
    frame_gap(n);
    chk("frame period", 64'(n), 64'(FRAME));
    frame_gap(n);
    frame_gap(n);
    // u0 after 4 steps: qx=12, qy=5; u1/u2 after 1 step: qx=qy=2
    wait_px(2, 2);
    chk("u1 fg (2,2)", 64'({g_dut[1].cr, g_dut[1].cg, g_dut[1].cb}), 64'hFFF);
    chk("u2 fg (2,2)", 64'({g_dut[2].cr, g_dut[2].cg, g_dut[2].cb}), 64'hFFFFFFFFF);
    wait_px(11, 5);
    chk("u0 bg (11,5)", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'h113377);
    wait_px(12, 5);
    chk("u0 fg (12,5)", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'hFFFFFF);
    wait_px(16, 5);
    chk("u2 blank (16,5)", 64'({g_dut[2].cr, g_dut[2].cg, g_dut[2].cb}), 64'h0);
    wait_px(15, 8);
    chk("u0 fg (15,8)", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'hFFFFFF);
    wait_px(12, 9);
    chk("u0 bg (12,9)", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'h113377);
    chk("u1 bg (12,9)", 64'({g_dut[1].cr, g_dut[1].cg, g_dut[1].cb}), 64'h137);
    chk("u2 bg (12,9)", 64'({g_dut[2].cr, g_dut[2].cg, g_dut[2].cb}), 64'h111333777);

    @(posedge clk); #2 pause = 1'b1;
    n = 0;
    repeat (5 * FRAME) begin
      @(negedge clk);
      if (g_dut[0].fr) n++;
    end
    chk("pulses while paused", 64'(n), 64'd5);
    @(posedge clk); #2 pause = 1'b0;

    repeat (40 * FRAME) @(negedge clk);
`ifdef VGA_BOUNCE_BORDER_EN
    wait_px(15, 6);
    chk("u0 border (15,6)", 64'({g_dut[0].cr, g_dut[0].cg, g_dut[0].cb}), 64'hFFFFFF);
`endif
    repeat (137) @(negedge clk);
    do_reset(n);
    chk("frame latency after mid reset", 64'(n), 64'd266);
    repeat (3 * FRAME) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: run not finished, required finish before 3000000 ns");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
